pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central hazard and flush controller that drives the per-stage stall and nullify lines consumed by every pipeline register stage.
- Stage register semantics:
  - nullify overrides stall.
  - nullify loads a bubble (control fields nullified).
  - stall holds the register contents.
- Converts hazard and exception requests from F/D/E/M/W into a coherent, prioritised stall/nullify vector plus a PC-redirect select.
- Sequences post-reset pipeline fill and post-exception drain.

Parameters:
- N_STAGE, 5, number of pipeline registers. Index 0=PC/F, 1=D, 2=E, 3=M, 4=W.
- DRAIN_CYCLES, 2, cycles the pipeline is held flushed after an exception/eret redirect (1..15).
- FILL_CYCLES, 4, cycles all stages are nullified after reset release (1..15).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- load_use_hazard  in  1  D consumer depends on load in E
- branch_taken  in  1  branch resolved taken in E (delay slot in D survives)
- muldiv_busy  in  1  E-stage mult/div not finished
- mem_wait  in  1  M-stage data memory not ready
- exception_req  in  1  exception committed in M
- eret_req  in  1  eret committed in M
- stall  out  N_STAGE  per-register hold
- nullify  out  N_STAGE  per-register bubble insert
- pc_redirect_sel  out  2  0=sequential, 1=branch, 2=exception vector, 3=EPC
- ctrl_state  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  cycles with any stall bit set, saturating

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = FILL, fill/drain counter = 0, stall_cycles = 0.
  - Outputs: stall = 0, nullify = all ones, pc_redirect_sel = 0.
- FSM states: FILL, NORMAL, DRAIN. All outputs are combinational from state plus inputs; state and counters are registered.
- FILL:
  - Outputs: nullify = all ones, stall = 0, pc_redirect_sel = 0. All hazard and exception inputs are ignored.
  - Counter increments each cycle. On the cycle it equals FILL_CYCLES-1, go to NORMAL and clear the counter.
- NORMAL: fixed priority, highest first; only the first active rule applies. All bits not listed are 0.
  1. exception_req or eret_req:
     - nullify[1..4] = 1, stall = 0.
     - pc_redirect_sel = 2 if exception_req, else 3 (exception wins when both are set).
     - Next state DRAIN.
  2. mem_wait: stall[0..3] = 1, nullify[4] = 1.
  3. muldiv_busy: stall[0..2] = 1, nullify[3] = 1.
  4. load_use_hazard: stall[0..1] = 1, nullify[2] = 1.
  5. branch_taken: nullify[1] = 1, pc_redirect_sel = 1. The delay slot in D advances normally.
  6. None active: all outputs 0, pc_redirect_sel = 0.
- load_use_hazard and branch_taken are mutually exclusive by construction. If both are seen, load_use_hazard wins and branch_taken stays asserted next cycle, because the branch is still in E.
- DRAIN:
  - Outputs: stall[0] = 1 (PC holds the redirect target), nullify[1..4] = 1, pc_redirect_sel = 0.
  - All inputs are ignored, including new exception_req, eret_req and mem_wait.
  - Counter runs 0..DRAIN_CYCLES-1, then state goes to NORMAL and the counter clears.
- stall_cycles:
  - Increments on each clock edge where |stall is 1, i.e. any stall bit set, including DRAIN.
  - Saturates at all ones and never wraps.
- A reset asserted in any state (including mid-DRAIN) returns immediately to FILL with counters cleared. There is no partial redirect.
- No output depends combinationally on stall_cycles. Latency from input to stall/nullify is zero cycles (same-cycle combinational).

Decomposition:
- Shared package pipeline_ctrl_pkg, containing:
  - stage_idx_e (F, D, E, M, W).
  - redirect_sel_e (SEQ, BRANCH, EXC_VEC, EPC).
  - ctrl_state_e (FILL, NORMAL, DRAIN).
  - Constant for the default N_STAGE.
- One sub-module, sat_counter (parameter CNT_W; ports en, clear, value), used for stall_cycles.
- FILL/DRAIN sequencing uses a local 4-bit counter inside the controller.

Test Plan:
- Reset release, no inputs active:
  - nullify = 5'b11111 for exactly 4 cycles, then 5'b00000.
  - ctrl_state goes FILL→NORMAL; stall_cycles = 0.
- NORMAL, load_use_hazard = 1 for 1 cycle:
  - stall = 5'b00011, nullify = 5'b00100 that cycle, then all 0.
  - stall_cycles increments to 1.
- mem_wait and muldiv_busy both high for 3 cycles:
  - mem_wait rule applies every cycle: stall = 5'b01111, nullify = 5'b10000.
  - stall_cycles = 3.
- exception_req together with eret_req and mem_wait:
  - That cycle: pc_redirect_sel = 2, nullify = 5'b11110, stall = 0.
  - Next 2 cycles: DRAIN with stall = 5'b00001, nullify = 5'b11110, inputs ignored.
  - Then NORMAL.
- branch_taken alone:
  - nullify = 5'b00010, pc_redirect_sel = 1, stall = 0.
  - stall_cycles unchanged.
- Reset asserted asynchronously mid-DRAIN (between edges):
  - Outputs immediately show stall = 0, nullify = 5'b11111, ctrl_state = FILL, stall_cycles = 0.
  - After release, the full 4-cycle FILL repeats.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared stage, redirect and controller-state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_N_STAGE_DEFAULT = 5;

    typedef enum logic [2:0] {
        STAGE_F = 3'd0,
        STAGE_D = 3'd1,
        STAGE_E = 3'd2,
        STAGE_M = 3'd3,
        STAGE_W = 3'd4
    } stage_idx_e;

    typedef enum logic [1:0] {
        SEL_SEQ     = 2'd0,
        SEL_BRANCH  = 2'd1,
        SEL_EXC_VEC = 2'd2,
        SEL_EPC     = 2'd3
    } redirect_sel_e;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_NORMAL = 2'd1,
        ST_DRAIN  = 2'd2
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (en && (value_q != '1)) begin
            value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Prioritised stall/nullify/redirect generator with fill/drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int N_STAGE      = c_N_STAGE_DEFAULT,
    parameter int DRAIN_CYCLES = 2,
    parameter int FILL_CYCLES  = 4,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_use_hazard,
    input  logic               branch_taken,
    input  logic               muldiv_busy,
    input  logic               mem_wait,
    input  logic               exception_req,
    input  logic               eret_req,
    output logic [N_STAGE-1:0] stall,
    output logic [N_STAGE-1:0] nullify,
    output logic [1:0]         pc_redirect_sel,
    output logic [1:0]         ctrl_state,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int         c_F          = int'(STAGE_F);
    localparam int         c_D          = int'(STAGE_D);
    localparam int         c_E          = int'(STAGE_E);
    localparam int         c_M          = int'(STAGE_M);
    localparam int         c_W          = int'(STAGE_W);
    localparam logic [3:0] c_FILL_LAST  = 4'(FILL_CYCLES - 1);
    localparam logic [3:0] c_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    ctrl_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    redirect_sel_e sel;
    logic          any_stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = '0;
        nullify = '0;
        sel     = SEL_SEQ;

        case (state_q)
            ST_FILL: begin
                nullify = '1;
                if (cnt_q == c_FILL_LAST) begin
                    state_d = ST_NORMAL;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_NORMAL: begin
                if (exception_req || eret_req) begin
                    nullify[c_D] = 1'b1;
                    nullify[c_E] = 1'b1;
                    nullify[c_M] = 1'b1;
                    nullify[c_W] = 1'b1;
                    sel          = exception_req ? SEL_EXC_VEC : SEL_EPC;
                    state_d      = ST_DRAIN;
                    cnt_d        = 4'd0;
                end else if (mem_wait) begin
                    stall[c_F]   = 1'b1;
                    stall[c_D]   = 1'b1;
                    stall[c_E]   = 1'b1;
                    stall[c_M]   = 1'b1;
                    nullify[c_W] = 1'b1;
                end else if (muldiv_busy) begin
                    stall[c_F]   = 1'b1;
                    stall[c_D]   = 1'b1;
                    stall[c_E]   = 1'b1;
                    nullify[c_M] = 1'b1;
                end else if (load_use_hazard) begin
                    // Holding F/D keeps the consumer; E gets a bubble while the load completes.
                    stall[c_F]   = 1'b1;
                    stall[c_D]   = 1'b1;
                    nullify[c_E] = 1'b1;
                end else if (branch_taken) begin
                    nullify[c_D] = 1'b1;
                    sel          = SEL_BRANCH;
                end
            end

            ST_DRAIN: begin
                // PC holds the redirect target loaded on the exception cycle.
                stall[c_F]   = 1'b1;
                nullify[c_D] = 1'b1;
                nullify[c_E] = 1'b1;
                nullify[c_M] = 1'b1;
                nullify[c_W] = 1'b1;
                if (cnt_q == c_DRAIN_LAST) begin
                    state_d = ST_NORMAL;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                nullify = '1;
                state_d = ST_FILL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign any_stall       = |stall;
    assign pc_redirect_sel = sel;
    assign ctrl_state      = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (any_stall),
        .clear (1'b0),
        .value (stall_cycles)
    );

endmodule
`default_nettype wire
